// File: rtl/nios_ram_reader_pkg.sv
// nios_ram_reader_pkg: FSM states, default widths and pointer sizing helper for the RAM reader.
package nios_ram_reader_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    localparam int ADDR_W_DEF       = 10;
    localparam int DATA_W_DEF       = 32;
    localparam int READ_LATENCY_DEF = 1;
    localparam int FIFO_DEPTH_DEF   = 4;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/nios_ram_reader_fifo.sv
// nios_ram_reader_fifo: first-word-fall-through return buffer; head is visible while not empty.
module nios_ram_reader_fifo
    import nios_ram_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF,
    localparam int AW    = clog2(DEPTH)
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wp_q, rp_q;
    logic [AW:0]       cnt_q;
    logic              wr, rd;
    assign rd    = pop && !empty;
    assign wr    = push && (!full || rd);
    assign full  = cnt_q == FULL_CNT;
    assign empty = cnt_q == '0;
    assign count = cnt_q;
    assign dout  = mem_q[rp_q];
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr) wp_q <= wp_q + 1'b1;
            if (rd) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
    always_ff @(posedge clk) if (wr) mem_q[wp_q] <= din;
endmodule

// File: rtl/nios_ram_reader.sv
// nios_ram_reader: Avalon-MM burst-less read master streaming (base, len) words through a credit-limited FIFO.
// Optional NIOS_RAM_READER_CSUM_EN adds a running sum of consumed words on port csum.
module nios_ram_reader
    import nios_ram_reader_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int READ_LATENCY = READ_LATENCY_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_start,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W:0]   cmd_len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_read,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic              avm_clken,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
`ifdef NIOS_RAM_READER_CSUM_EN
    output logic [DATA_W-1:0] csum,
`endif
    input  logic              out_ready
);
    localparam int CW = clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CREDITS = CW'(FIFO_DEPTH);
    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [ADDR_W:0]         len_q, len_d, issued_q, issued_d, returned_q, returned_d;
    logic [READ_LATENCY-1:0] pipe_q;
    logic [CW-1:0]           inflight, fifo_count, cnt_nx;
    logic                    issue, push, pop, fifo_full, fifo_empty;
    // Every word in flight or buffered holds a credit, so the FIFO can never be overrun.
    assign inflight = CW'($countones(pipe_q));
    assign issue    = state_q == ISSUE && issued_q != len_q && !fifo_full && fifo_count + inflight < CREDITS;
    assign push     = pipe_q[READ_LATENCY-1];
    assign pop      = out_valid && out_ready;
    assign cnt_nx   = fifo_count + CW'(push) - CW'(pop);
    assign out_valid      = !fifo_empty;
    assign busy           = state_q != IDLE;
    assign done           = state_q == DONE;
    assign avm_address    = addr_q;
    assign avm_read       = issue;
    assign avm_chipselect = issue;
    assign avm_write      = 1'b0;
    assign avm_byteenable = 4'hF;
    assign avm_clken      = 1'b1;
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        issued_d   = issued_q;
        returned_d = returned_q + (ADDR_W+1)'(push);
        case (state_q)
            IDLE: if (cmd_start) begin
                state_d    = ISSUE;
                addr_d     = cmd_base;
                len_d      = cmd_len;
                issued_d   = '0;
                returned_d = '0;
            end
            ISSUE: begin
                if (issue) begin
                    addr_d   = addr_q + 1'b1;
                    issued_d = issued_q + 1'b1;
                end
                if (issued_q == len_q) state_d = DRAIN;
            end
            // Look at post-edge occupancy so done follows the last accept by one cycle.
            DRAIN: if (returned_d == len_q && cnt_nx == '0) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            returned_q <= '0;
            pipe_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            returned_q <= returned_d;
            pipe_q     <= (pipe_q << 1) | READ_LATENCY'(issue);
        end
    end
    nios_ram_reader_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (push),
        .pop    (pop),
        .din    (avm_readdata),
        .dout   (out_data),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );
`ifdef NIOS_RAM_READER_CSUM_EN
    logic [DATA_W-1:0] csum_q;
    always_ff @(posedge clk) begin
        if (!reset_n) csum_q <= '0;
        else if (state_q == IDLE && cmd_start) csum_q <= '0;
        else if (pop) csum_q <= csum_q + out_data;
    end
    assign csum = csum_q;
`endif
endmodule

// File: tb/tb_nios_ram_reader.sv
// tb_nios_ram_reader: random and directed commands against a queue-based reference of the read stream.
module tb_nios_ram_reader;
    localparam int AW = 10;
    localparam int DEPTH = 4;
    logic clk = 1'b0, reset_n = 1'b0, cmd_start = 1'b0, out_ready = 1'b0;
    logic [AW-1:0] cmd_base = '0;
    logic [AW:0] cmd_len = '0;
    logic busy, done, avm_chipselect, avm_read, avm_write, avm_clken, out_valid;
    logic [AW-1:0] avm_address;
    logic [3:0] avm_byteenable;
    logic [31:0] avm_readdata, out_data;
    logic [AW-1:0] ram_addr_q = '0;
`ifdef NIOS_RAM_READER_CSUM_EN
    logic [31:0] csum;
`endif
    nios_ram_reader dut (
        .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_base(cmd_base), .cmd_len(cmd_len),
        .busy(busy), .done(done), .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_read(avm_read), .avm_write(avm_write), .avm_byteenable(avm_byteenable), .avm_clken(avm_clken),
        .avm_readdata(avm_readdata), .out_data(out_data), .out_valid(out_valid),
`ifdef NIOS_RAM_READER_CSUM_EN
        .csum(csum),
`endif
        .out_ready(out_ready)
    );
    function automatic logic [31:0] mem(input logic [AW-1:0] a);
        return 32'(a) * 32'h01010101;
    endfunction
    always #5 clk = ~clk;
    always @(posedge clk) ram_addr_q <= avm_address;
    assign avm_readdata = mem(ram_addr_q);
    int total = 0, bad = 0, cyc = 0;
    int outstanding = 0, cmd_reads = 0, acc_cnt = 0, m_len = 0;
    int start_cyc = 0, done_cyc = 0, done_cnt = 0, first_acc = 0, last_acc = 0, rd_first = 0, rd_last = 0;
    bit m_busy = 0, rst_prev = 0, rnd = 0;
    logic [AW-1:0] exp_addr [$];
    logic [31:0] exp_data [$];
    logic [31:0] acc_log [1024];
    logic [AW-1:0] rd_log [1024];
    logic [31:0] m_sum = '0;
    task automatic chk(input string n, input longint a, input longint e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask
    always @(negedge clk) begin
        cyc++;
        if (rst_prev) begin
            chk("rst_busy", longint'(busy), 0);
            chk("rst_done", longint'(done), 0);
            chk("rst_read", longint'(avm_read), 0);
            chk("rst_cs", longint'(avm_chipselect), 0);
            chk("rst_addr", longint'(avm_address), 0);
            chk("rst_valid", longint'(out_valid), 0);
        end
        if (!reset_n) begin
            exp_addr.delete();
            exp_data.delete();
            m_busy = 0;
            outstanding = 0;
            rst_prev = 1;
        end else begin
            rst_prev = 0;
            chk("busy", longint'(busy), longint'(m_busy));
            chk("tie_write", longint'(avm_write), 0);
            chk("tie_be", longint'(avm_byteenable), 15);
            chk("tie_clken", longint'(avm_clken), 1);
            chk("cs_eq_read", longint'(avm_chipselect), longint'(avm_read));
            if (avm_read) begin
                chk("read_expected", longint'(exp_addr.size() != 0), 1);
                if (exp_addr.size() != 0) chk("rd_addr", longint'(avm_address), longint'(exp_addr.pop_front()));
                if (cmd_reads == 0) rd_first = cyc;
                rd_last = cyc;
                if (cmd_reads < 1024) rd_log[cmd_reads] = avm_address;
                cmd_reads++;
                outstanding++;
            end
            if (out_valid && out_ready) begin
                chk("acc_expected", longint'(exp_data.size() != 0), 1);
                if (exp_data.size() != 0) chk("out_data", longint'(out_data), longint'(exp_data.pop_front()));
                if (acc_cnt == 0) first_acc = cyc;
                last_acc = cyc;
                if (acc_cnt < 1024) acc_log[acc_cnt] = out_data;
                acc_cnt++;
                m_sum += out_data;
                outstanding--;
            end
            chk("credit", longint'(outstanding <= DEPTH), 1);
            if (done) begin
                chk("done_when_busy", longint'(m_busy), 1);
                chk("done_data_left", longint'(exp_data.size()), 0);
                chk("done_reads_left", longint'(exp_addr.size()), 0);
                if (m_len == 0) chk("done_lat_len0", longint'(cyc - start_cyc), 3);
                else chk("done_after_acc", longint'(cyc - last_acc), 1);
`ifdef NIOS_RAM_READER_CSUM_EN
                chk("csum", longint'(csum), longint'(m_sum));
`endif
                done_cnt++;
                done_cyc = cyc;
                m_busy = 0;
            end else if (!m_busy && cmd_start) begin
                m_busy = 1;
                start_cyc = cyc;
                m_len = int'(cmd_len);
                cmd_reads = 0;
                acc_cnt = 0;
                m_sum = '0;
                for (int i = 0; i < m_len; i++) begin
                    exp_addr.push_back(AW'(int'(cmd_base) + i));
                    exp_data.push_back(mem(AW'(int'(cmd_base) + i)));
                end
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
    endtask
    task automatic start(input int b, input int l);
        cmd_base = AW'(b);
        cmd_len = (AW+1)'(l);
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask
    task automatic wait_done(input string n);
        int d0 = done_cnt;
        int k = 0;
        while (done_cnt == d0 && k < 3000) begin
            tick();
            k++;
        end
        chk({n, "_done_seen"}, longint'(done_cnt != d0), 1);
        tick();
    endtask
    initial begin
        logic [AW-1:0] s2 [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        int d0, k;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        out_ready = 1'b1;
        start(32'h010, 4);
        wait_done("s1");
        chk("s1_d0", longint'(acc_log[0]), 64'h10101010);
        chk("s1_d3", longint'(acc_log[3]), 64'h13131313);
        chk("s1_rd_first", longint'(rd_first - start_cyc), 1);
        chk("s1_rd_span", longint'(rd_last - rd_first), 3);
        chk("s1_acc_span", longint'(last_acc - first_acc), 3);
        chk("s1_done_lat", longint'(done_cyc - last_acc), 1);
`ifdef NIOS_RAM_READER_CSUM_EN
        chk("s1_csum", longint'(csum), 64'h46464646);
`endif
        start(32'h3FE, 4);
        wait_done("s2");
        for (int i = 0; i < 4; i++) chk("s2_addr", longint'(rd_log[i]), longint'(s2[i]));
        chk("s2_d2", longint'(acc_log[2]), 0);
        chk("s2_d3", longint'(acc_log[3]), 64'h01010101);
        out_ready = 1'b0;
        start(32'h020, 8);
        repeat (10) tick();
        chk("s3_stall_reads", longint'(cmd_reads), DEPTH);
        chk("s3_stall_read_low", longint'(avm_read), 0);
        out_ready = 1'b1;
        wait_done("s3");
        chk("s3_count", longint'(acc_cnt), 8);
        chk("s3_d7", longint'(acc_log[7]), 64'h27272727);
        start(32'h055, 0);
        wait_done("s4");
        chk("s4_lat", longint'(done_cyc - start_cyc), 3);
        chk("s4_reads", longint'(cmd_reads), 0);
        start(32'h040, 16);
        tick();
        start(32'h100, 16);
        wait_done("s5");
        chk("s5_count", longint'(acc_cnt), 16);
        chk("s5_a0", longint'(rd_log[0]), 64'h040);
        chk("s5_d15", longint'(acc_log[15]), 64'h4F4F4F4F);
        start(32'h300, 32);
        k = 0;
        while (acc_cnt < 5 && k < 100) begin
            tick();
            k++;
        end
        chk("s6_reach5", longint'(acc_cnt >= 5), 1);
        d0 = done_cnt;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("s6_busy", longint'(busy), 0);
        chk("s6_valid", longint'(out_valid), 0);
        repeat (40) tick();
        chk("s6_no_done", longint'(done_cnt), longint'(d0));
        start(32'h022, 3);
        wait_done("s6b");
        chk("s6b_d0", longint'(acc_log[0]), 64'h22222222);
        chk("s6b_count", longint'(acc_cnt), 3);
        start(32'h3FF, 1024);
        wait_done("full");
        chk("full_count", longint'(acc_cnt), 1024);
        chk("full_last", longint'(rd_log[1023]), 64'h3FE);
        rnd = 1'b1;
        for (int n = 0; n < 25; n++) begin
            start(int'($urandom_range(0, 1023)), int'($urandom_range(1, 40)));
            if ($urandom_range(0, 1) == 1) start(int'($urandom_range(0, 1023)), int'($urandom_range(0, 40)));
            wait_done("rnd");
        end
        rnd = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
